// File: rtl/pc_sequencer.sv
// Program-counter sequencer: launches one of three resident programs, steps or
// branches the PC each cycle, and reports completion, faults and retired count.
module pc_sequencer #(
   parameter logic [7:0] ENTRY0    = 8'd0,
   parameter logic [7:0] ENTRY1    = 8'd27,
   parameter logic [7:0] ENTRY2    = 8'd46,
   parameter logic [7:0] PC_MAX    = 8'd65,
   parameter logic [8:0] HALT_CODE = 9'h000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [1:0]  ProgSel,
   input  logic [8:0]  Iptr,
   input  logic        BranchTaken,
   input  logic [7:0]  BranchTarget,
   input  logic        Stall,
   output logic [7:0]  PC,
   output logic        Busy,
   output logic        Done,
   output logic        Fault,
   output logic [15:0] InstrCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      nextState;
   logic [7:0]  pcNext;
   logic [15:0] countNext;
   logic [15:0] countInc;
   logic        faultNext;

   // Retired-instruction count sticks at all-ones rather than wrapping.
   assign countInc = (InstrCount == 16'hFFFF) ? InstrCount : InstrCount + 16'd1;

   assign Busy = (state == RUN);
   assign Done = (state == DONE);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         PC         <= 8'd0;
         InstrCount <= 16'd0;
         Fault      <= 1'b0;
      end else begin
         state      <= nextState;
         PC         <= pcNext;
         InstrCount <= countNext;
         Fault      <= faultNext;
      end
   end

   // Halt outranks a branch, which outranks the end-of-memory check.
   always_comb begin
      nextState = state;
      pcNext    = PC;
      countNext = InstrCount;
      faultNext = Fault;
      case (state)
         IDLE: begin
            if (Start) begin
               if (ProgSel == 2'd3) begin
                  faultNext = 1'b1;
               end else begin
                  nextState = RUN;
                  countNext = 16'd0;
                  faultNext = 1'b0;
                  case (ProgSel)
                     2'd0:    pcNext = ENTRY0;
                     2'd1:    pcNext = ENTRY1;
                     default: pcNext = ENTRY2;
                  endcase
               end
            end
         end
         RUN: begin
            if (!Stall) begin
               if (Iptr == HALT_CODE) begin
                  nextState = DONE;
               end else if (BranchTaken) begin
                  pcNext    = BranchTarget;
                  countNext = countInc;
                  if (BranchTarget > PC_MAX) begin
                     faultNext = 1'b1;
                     nextState = DONE;
                  end
               end else if (PC == PC_MAX) begin
                  faultNext = 1'b1;
                  nextState = DONE;
                  countNext = countInc;
               end else begin
                  pcNext    = PC + 8'd1;
                  countNext = countInc;
               end
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Parameters
REQ-001 SHALL have parameter ENTRY0, default 8'd0, meaning start PC of program 0 (multiply).
REQ-002 SHALL have parameter ENTRY1, default 8'd27, meaning start PC of program 1 (string match).
REQ-003 SHALL have parameter ENTRY2, default 8'd46, meaning start PC of program 2 (closest pair).
REQ-004 SHALL have parameter PC_MAX, default 8'd65, meaning highest legal PC.
REQ-005 SHALL have parameter HALT_CODE, default 9'h000, meaning the iptr encoding that terminates a program.

Interface
REQ-006 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port Start, input, 1 bit: request to launch the program selected by ProgSel.
REQ-009 SHALL have port ProgSel, input, 2 bits: program select; 0/1/2 are valid and 3 is illegal.
REQ-010 SHALL have port Iptr, input, 9 bits: instruction pointer returned by imem for the current PC.
REQ-011 SHALL have port BranchTaken, input, 1 bit: the datapath resolves a taken branch this cycle.
REQ-012 SHALL have port BranchTarget, input, 8 bits: next PC when BranchTaken=1.
REQ-013 SHALL have port Stall, input, 1 bit: hold the current PC.
REQ-014 SHALL have port PC, output, 8 bits: drives the imem address.
REQ-015 SHALL have port Busy, output, 1 bit: high in RUN.
REQ-016 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port Fault, output, 1 bit: sticky error flag.
REQ-018 SHALL have port InstrCount, output, 16 bits: count of retired instructions in the current or last run.

Function
REQ-019 SHALL implement the states IDLE, RUN and DONE.
REQ-020 SHALL, in IDLE with Start=1 and ProgSel<3: load PC with the matching ENTRYn, clear InstrCount and Fault, and go to RUN on the next edge.
REQ-021 SHALL, in IDLE with Start=1 and ProgSel=3: set Fault, stay in IDLE, and leave PC unchanged.
REQ-022 SHALL, in RUN with Stall=1: hold PC and InstrCount, ignore BranchTaken, and suppress halt detection.
REQ-023 SHALL, in RUN with Stall=0, apply this priority order:
- (a) Iptr==HALT_CODE: go to DONE, hold PC, do not count.
- (b) BranchTaken=1: PC<=BranchTarget and count one instruction; if BranchTarget>PC_MAX, also set Fault and go to DONE.
- (c) otherwise, with PC==PC_MAX: set Fault, go to DONE, hold PC, count one instruction.
- (d) otherwise: PC<=PC+1 and count one instruction.
REQ-024 SHALL saturate InstrCount at 16'hFFFF with no wrap.
REQ-025 SHALL assert Done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-026 SHALL ignore Start in RUN and in DONE, with no effect on PC, counts or state.
REQ-027 SHALL drive Busy combinationally as (state==RUN).
REQ-028 SHALL hold PC, InstrCount and Fault in IDLE until the next accepted Start.
REQ-029 SHALL keep Done independent of Stall; Stall has effect only in RUN.
REQ-030 SHALL produce PC at zero latency to imem; Iptr is combinational from PC within the same cycle.

Reset
REQ-031 SHALL, on Reset=1 at any time including mid-run, immediately force state=IDLE, PC=0, InstrCount=0, Fault=0, Done=0 and Busy=0.
REQ-032 SHALL, after Reset deasserts, take no action until the first Start.

Verification
REQ-033 SHALL cover: Start, ProgSel=0, no branches, imem model halting at PC 26 -> PC steps 0..26, one Done pulse, InstrCount=26, Fault=0.
REQ-034 SHALL cover: ProgSel=1 with BranchTaken at PC 38 and target 30 for 2 iterations -> PC 27..38,30..38,30..45, then Done, Fault=0.
REQ-035 SHALL cover: ProgSel=3 in IDLE -> Fault=1, Busy=0, PC unchanged; a following ProgSel=2 start clears Fault and PC=46.
REQ-036 SHALL cover: Stall=1 for 3 cycles at PC 50 with BranchTaken=1 -> PC stays 50 and InstrCount is unchanged during the stall.
REQ-037 SHALL cover: a halt-free stream reaching PC 65 -> Fault=1 and a Done pulse; BranchTarget=8'd70 -> Fault=1 and Done.
REQ-038 SHALL cover: Reset asserted mid-RUN at PC 12 -> outputs zero asynchronously, state IDLE; Start during RUN ignored.
